// File: rtl/mano_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mano_timing_sequencer
//  Description : Sequence counter and run control for the basic-computer
//                control unit. Produces one-hot timing t0..t7, latches the
//                instruction class (q1..q3) at the end of t2, sizes each
//                instruction to its class and counts retired instructions.
//  Ports       :
//    clk          rising-edge clock
//    reset_n      asynchronous active-low reset
//    start        level, IDLE -> RUN (wins over step)
//    halt         level, stop at the next instruction boundary
//    step         level, IDLE -> STEP (one instruction)
//    stall        freeze the sequence (memory wait)
//    opcode[1:0]  class field sampled on the unstalled edge ending t2
//    t[7:0]       one-hot timing, zero when not running
//    q1,q2,q3     latched instruction class
//    running      high in RUN or STEP
//    instr_done   high during the final timing step (unstalled)
//    illegal      pulse during t3 of an illegal (00) opcode
//    instr_count  retired instructions, wraps modulo 2^CNT_W
//  Revision    : 1.0 - initial release
// ============================================================================
module mano_timing_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt,
    input  logic             step,
    input  logic             stall,
    input  logic [1:0]       opcode,
    output logic [7:0]       t,
    output logic             q1,
    output logic             q2,
    output logic             q3,
    output logic             running,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_sc, w_sc_nxt;
    logic [2:0]       r_q, w_q_nxt;          // {q3, q2, q1}
    logic             r_halt_pending, w_halt_pending_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             w_active;
    logic             w_last;
    logic [2:0]       w_decode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_sc           <= 3'd0;
            r_q            <= 3'b000;
            r_halt_pending <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sc           <= w_sc_nxt;
            r_q            <= w_q_nxt;
            r_halt_pending <= w_halt_pending_nxt;
            r_count        <= w_count_nxt;
        end
    end

    always_comb begin
        case (opcode)
            2'b01:   w_decode = 3'b001;
            2'b10:   w_decode = 3'b010;
            2'b11:   w_decode = 3'b100;
            default: w_decode = 3'b000;
        endcase
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_sc_nxt           = r_sc;
        w_q_nxt            = r_q;
        w_halt_pending_nxt = r_halt_pending;
        w_count_nxt        = r_count;
        t                  = 8'h00;
        running            = 1'b0;
        instr_done         = 1'b0;
        illegal            = 1'b0;
        w_active           = (r_state == S_RUN) || (r_state == S_STEP);
        w_last             = 1'b0;

        if (w_active) begin
            running = 1'b1;
            t       = 8'd1 << r_sc;
            // An empty class at t3 is an illegal opcode; it retires there too.
            w_last  = ((r_sc == 3'd3) && (r_q[0] || (r_q == 3'b000))) ||
                      ((r_sc == 3'd5) && r_q[1]) ||
                      ((r_sc == 3'd7) && r_q[2]);
        end

        // halt is captured even while stalled so it is never lost.
        if ((r_state == S_RUN) && halt) begin
            w_halt_pending_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else if (step) begin
                    w_state_nxt = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                if (!stall) begin
                    if (w_last) begin
                        instr_done         = 1'b1;
                        illegal            = (r_q == 3'b000);
                        w_sc_nxt           = 3'd0;
                        w_q_nxt            = 3'b000;
                        w_count_nxt        = r_count + c_cnt_one;
                        w_halt_pending_nxt = 1'b0;
                        if ((r_state == S_STEP) || r_halt_pending || halt) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_sc_nxt = r_sc + 3'd1;
                        if (r_sc == 3'd2) begin
                            w_q_nxt = w_decode;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign q1          = r_q[0];
    assign q2          = r_q[1];
    assign q3          = r_q[2];
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mano_timing_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mano_timing_sequencer
//  Description : Randomised bench for mano_timing_sequencer. A behavioural
//                model tracks mode, position within the instruction and the
//                instruction length implied by its class; each cycle's
//                expected outputs are queued and a monitor compares them with
//                the DUT on the falling edge. A second instance with a 2-bit
//                counter checks wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mano_timing_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start, halt, step, stall;
    logic [1:0]  opcode;
    logic [7:0]  t;
    logic        q1, q2, q3, running, instr_done, illegal;
    logic [15:0] instr_count;
    logic [7:0]  t_b;
    logic        q1_b, q2_b, q3_b, running_b, instr_done_b, illegal_b;
    logic [1:0]  instr_count_b;

    always #5 clk = ~clk;

    mano_timing_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .step(step), .stall(stall), .opcode(opcode), .t(t),
        .q1(q1), .q2(q2), .q3(q3), .running(running),
        .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    mano_timing_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
        .step(step), .stall(stall), .opcode(opcode), .t(t_b),
        .q1(q1_b), .q2(q2_b), .q3(q3_b), .running(running_b),
        .instr_done(instr_done_b), .illegal(illegal_b),
        .instr_count(instr_count_b)
    );

    typedef struct packed {
        logic [7:0]  t;
        logic        q1, q2, q3, running, done, illegal;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: mode 0=idle 1=run 2=step; pos = timing step within instruction;
    // len = total steps of the instruction once its class is known (0 before).
    int          m_mode, m_pos, m_len, m_cls;
    bit          m_hp;
    int unsigned m_count;

    function automatic int class_len(int c);
        if (c == 2) return 6;
        if (c == 3) return 8;
        return 4;               // q1 and illegal both finish at t3
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_len = 0; m_cls = 0; m_hp = 0; m_count = 0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_mode == 1 && halt) m_hp = 1;
        if (m_mode == 0) begin
            if (start)     begin m_mode = 1; m_pos = 0; end
            else if (step) begin m_mode = 2; m_pos = 0; end
        end else if (!stall) begin
            if (m_pos == 2) begin
                m_cls = int'(opcode);
                m_len = class_len(m_cls);
            end
            if (m_pos >= 3 && m_pos == m_len - 1) begin
                m_count = (m_count + 1) % 65536;
                if (m_mode == 2 || m_hp || halt) m_mode = 0;
                m_hp = 0; m_pos = 0; m_cls = 0; m_len = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        bit   run;
        run       = (m_mode != 0);
        e.t       = run ? 8'(1 << m_pos) : 8'h00;
        e.q1      = (m_cls == 1);
        e.q2      = (m_cls == 2);
        e.q3      = (m_cls == 3);
        e.running = run;
        e.done    = run && !stall && m_pos >= 3 && m_pos == m_len - 1;
        e.illegal = e.done && (m_cls == 0);
        e.cnt     = m_count[15:0];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("t",           32'(t),             32'(mon_e.t));
            check("q1",          32'(q1),            32'(mon_e.q1));
            check("q2",          32'(q2),            32'(mon_e.q2));
            check("q3",          32'(q3),            32'(mon_e.q3));
            check("running",     32'(running),       32'(mon_e.running));
            check("instr_done",  32'(instr_done),    32'(mon_e.done));
            check("illegal",     32'(illegal),       32'(mon_e.illegal));
            check("instr_count", 32'(instr_count),   32'(mon_e.cnt));
            check("count_w2",    32'(instr_count_b), 32'(mon_e.cnt[1:0]));
            check("t_w2",        32'(t_b),           32'(mon_e.t));
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; halt = 1'b0; step = 1'b0;
        stall = 1'b0; opcode = 2'b00;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_edge();
            #1;
            // Reset asserted between edges: outputs must already be zero at
            // the following falling edge, exercising the asynchronous path.
            reset_n = (cyc < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
            start   = ($urandom_range(0, 7) == 0);
            step    = ($urandom_range(0, 7) == 0);
            halt    = ($urandom_range(0, 11) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            opcode  = 2'($urandom_range(0, 3));
            if (!reset_n) model_reset();
            sb.push_back(model_outputs());
        end
        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mano_timing_sequencer.md
Name: mano_timing_sequencer

Overview:
- Sequence-counter and run-control block for the basic computer's control unit.
- Generates the one-hot timing signals t0..t7 and the latched instruction-class flags q1..q3 that the control-logic decoder combines into datapath enables x1..x8.
- Sizes each instruction to its class, supports run/halt/single-step and memory stall, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  level; begin continuous execution from IDLE.
- halt  input  1  level; stop at the next instruction boundary.
- step  input  1  level; execute exactly one instruction from IDLE.
- stall  input  1  freeze the sequence (memory wait).
- opcode  input  2  class field of the word being loaded into IR during t2: 01=q1, 10=q2, 11=q3, 00=illegal.
- t  output  8  one-hot timing; t[i] is ti; all zero when not running.
- q1, q2, q3  output  1 each  latched instruction class, at most one high.
- running  output  1  high in RUN or STEP.
- instr_done  output  1  high during the final timing step of an instruction, when stall=0.
- illegal  output  1  one-cycle pulse on an illegal opcode.
- instr_count  output  CNT_W  retired instructions (illegal ones included), wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE, 3-bit sc=0, t=8'h00, q1..q3=0, running=0, instr_done=0, illegal=0, instr_count=0, halt_pending=0.
  - Reset asserted mid-instruction aborts it immediately; no done pulse and no count.
- States are IDLE, RUN and STEP.
  - IDLE: t=0, running=0. start=1 moves to RUN; otherwise step=1 moves to STEP. start wins if both are high. halt is ignored in IDLE.
  - The first cycle after the transition has t=8'h01 (t0), sc=0. Latency from start sampled to t0 is 1 cycle.
  - RUN/STEP: t = one-hot decode of sc; running=1. start and step are ignored.
- Sequencing on each edge when stall=0:
  - sc increments.
  - On the edge ending t2, opcode is decoded into q1..q3, which are then valid from t3 onward.
  - Last step per class: q1 ends at t3, q2 at t5, q3 at t7. An illegal opcode ends at t3 with illegal=1 during that t3 cycle and q1..q3 all 0.
  - instr_done=1 during the last step.
  - On the edge ending the last step: sc←0, q1..q3←0, instr_count increments.
- Next state after the last step:
  - STEP, or RUN with halt_pending=1 or halt=1: go to IDLE, clear halt_pending, t=0 next cycle.
  - Otherwise: continue in RUN with t0 next cycle; there is no idle gap between instructions.
- halt semantics:
  - halt sampled high in RUN at any step sets halt_pending.
  - The current instruction always completes; halt never truncates it.
- stall semantics:
  - stall=1 holds sc, t, q1..q3, state and instr_count unchanged.
  - instr_done and illegal are forced 0 while stalled.
  - The opcode is not sampled during a stalled t2; it is sampled on the first unstalled edge ending t2.
  - halt is still captured into halt_pending during a stall.
- Invariants: t is one-hot or zero. sc never exceeds 7. q1..q3 are zero during t0..t2. No x/z on outputs after reset.

Test Plan:
- Reset, start pulse, opcode=10 at t2 -> t walks 01,02,04,08,10,20; q2=1 during t3..t5; instr_done during t5; instr_count=1; next cycle t=01.
- opcode=01 with stall=1 for 2 cycles during t1 -> t=02 for 3 cycles; q1 during t3; instruction completes in 6 cycles total; count +1.
- RUN, opcode=11, halt pulsed during t4 -> sequence continues through t7 with instr_done; IDLE next cycle with t=00, running=0.
- IDLE, step pulse with opcode=10 -> exactly one instruction (t0..t5), then IDLE; count=1; start+step together -> RUN.
- opcode=00 -> illegal=1 and instr_done=1 at t3, q1..q3=0, sc back to 0, count +1.
- CNT_W=2, run 5 instructions -> instr_count 1,2,3,0,1. reset_n low during t4 -> all outputs 0 asynchronously.
